// File: rtl/pix_stream_src_p.sv
// pix_stream_src_p: reads one HEIGHT x WIDTH frame from a synchronous-read
// image RAM (one P-pixel word per address) and emits it in raster order on a
// valid/ready stream with start-of-line / end-of-frame flags. A 2-entry skid
// FIFO absorbs the one-cycle RAM latency so stalls never drop or repeat words.
// Optional build macro PIXSRC_ZPAD_EN: wraps the frame with one all-zero row
// above and below (HEIGHT+2 rows); zero words are injected without RAM reads.
module pix_stream_src_p #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int BITW   = 8,
    parameter int P      = 4,
    parameter int ADDRW  = $clog2(WIDTH * HEIGHT / P)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDRW-1:0]  mem_rd_addr,
    input  logic [P*BITW-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P*BITW-1:0] out_pix_vec,
    output logic              out_sol,
    output logic              out_eof
);

    localparam int WPR    = WIDTH / P;
    localparam int NWORDS = WPR * HEIGHT;
`ifdef PIXSRC_ZPAD_EN
    localparam int ROWS   = HEIGHT + 2;
    localparam int TOTAL  = ROWS * WPR;
    localparam int SRCW   = $clog2(TOTAL + 1);
`else
    localparam int ROWS   = HEIGHT;
`endif
    localparam int COLW   = $clog2(WIDTH + 1);
    localparam int ROWW   = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDRW-1:0]  rd_addr;
    logic              inflight;
    logic [P*BITW-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [COLW-1:0]   col;
    logic [ROWW-1:0]   row;
    logic              eof_sent;

    logic              start_acc;
    logic              pop;
    logic              push;
    logic              slot;
    logic              rd_fire;
    logic              last_issue;
    logic              flush_ok;
    logic [2:0]        occ;
    logic [P*BITW-1:0] push_data;

    assign start_acc = (state == IDLE) && start;
    assign pop       = out_valid && out_ready;
    // Words already owned (stored + returning) after this cycle's pop; a new
    // issue is allowed only while that leaves a free FIFO slot for it.
    assign occ       = 3'(count) + 3'(inflight) - 3'(pop);
    assign slot      = (state == RUN) && (occ < 3'd2);

`ifdef PIXSRC_ZPAD_EN
    logic [SRCW-1:0] src_idx;
    logic            in_data;
    logic            zero_fire;

    assign in_data    = (src_idx >= SRCW'(WPR)) && (src_idx < SRCW'(WPR * (HEIGHT + 1)));
    assign rd_fire    = slot && in_data;
    // Zero words push the same cycle, so they wait for any returning read
    // to land first to keep raster order.
    assign zero_fire  = slot && !in_data && !inflight;
    assign last_issue = (rd_fire || zero_fire) && (src_idx == SRCW'(TOTAL - 1));
    assign push       = inflight || zero_fire;
    assign push_data  = zero_fire ? '0 : mem_rd_data;

    // Source position across the padded frame (zero rows plus RAM rows)
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            src_idx <= '0;
        end else if (rd_fire || zero_fire) begin
            src_idx <= src_idx + SRCW'(1);
        end
    end
`else
    assign rd_fire    = slot;
    assign last_issue = rd_fire && (rd_addr == ADDRW'(NWORDS - 1));
    assign push       = inflight;
    assign push_data  = mem_rd_data;
`endif

    assign flush_ok = (count == 2'd0) && !inflight && eof_sent;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)      state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = FLUSH;
            FLUSH:   if (flush_ok)   state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FLUSH) && flush_ok;
        mem_rd_en = rd_fire;
    end

    // RAM word address, one step per issued read, wrapping at frame end
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            rd_addr <= '0;
        end else if (rd_fire) begin
            rd_addr <= (rd_addr == ADDRW'(NWORDS - 1)) ? '0 : rd_addr + ADDRW'(1);
        end
    end

    assign mem_rd_addr = rd_addr;

    // Read-in-flight flag: RAM data is valid the cycle after the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_fire;
        end
    end

    // 2-entry skid FIFO; push into the slot a simultaneous pop is vacating
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign out_valid   = (count != 2'd0);
    assign out_pix_vec = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_sol     = out_valid && (col == '0);
    assign out_eof     = out_valid && (row == ROWW'(ROWS - 1)) && (col == COLW'(WIDTH - P));

    // Output raster position, advancing on each transfer
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (col == COLW'(WIDTH - P)) begin
                col <= '0;
                row <= row + ROWW'(1);
            end else begin
                col <= col + COLW'(P);
            end
        end
    end

    // Remembers that the frame's last word has left, gating the done pulse
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            eof_sent <= 1'b0;
        end else if (pop && out_eof) begin
            eof_sent <= 1'b1;
        end
    end

endmodule
